// File: rtl/z80_ind_jp_seq_pkg.sv
// Shared types for the indirect-jump fetch sequencer: pointer select
// encoding and the sequencer state enumeration.
package z80_ind_jp_seq_pkg;

  typedef enum logic [1:0] {
    PTR_HL = 2'd0,
    PTR_IX = 2'd1,
    PTR_IY = 2'd2,
    PTR_SP = 2'd3
  } ptr_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // SP selects pop mode, which also writes back the advanced stack pointer.
  function automatic logic is_pop(input logic [1:0] sel);
    return sel == PTR_SP;
  endfunction

endpackage

// File: rtl/z80_ind_jp_seq_le_assemble.sv
// Little-endian byte-lane assembly register; value reflects the stored
// lanes with the in-flight write already merged in.
module z80_le_assemble #(
  parameter int NBYTES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  wr,
  input  logic [1:0]            lane,
  input  logic [7:0]            data,
  output logic [8*NBYTES-1:0]   value
);

  logic [NBYTES-1:0][7:0] q;
  logic [NBYTES-1:0][7:0] nxt;

  for (genvar g = 0; g < NBYTES; g++) begin : g_lane
    logic hit;
    assign hit    = wr && (lane == 2'(g));
    assign nxt[g] = hit ? data : q[g];

    always_ff @(posedge clk) begin
      if (reset || clear) q[g] <= 8'h00;
      else if (hit)       q[g] <= data;
    end
  end

  assign value = nxt;

endmodule

// File: rtl/z80_ind_jp_seq.sv
// Indirect jump target fetch: reads NBYTES little-endian bytes from the
// selected pointer and emits the assembled target (plus new SP in pop mode).
module z80_ind_jp_seq
  import z80_ind_jp_seq_pkg::*;
#(
  parameter int NBYTES = 2,
  parameter int ADDR_W = 16,
  localparam int IP_W  = 8 * NBYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        ptr_sel,
  input  logic [ADDR_W-1:0] reg_hl_in,
  input  logic [ADDR_W-1:0] reg_ix_in,
  input  logic [ADDR_W-1:0] reg_iy_in,
  input  logic [ADDR_W-1:0] reg_sp_in,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic              mem_ready,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic [IP_W-1:0]   reg_ip_out,
  output logic              reg_ip_wr,
  output logic [ADDR_W-1:0] reg_sp_out,
  output logic              reg_sp_wr
);

  localparam logic [1:0] LAST_K = 2'(NBYTES - 1);

  state_e            state;
  logic [ADDR_W-1:0] base;
  logic [1:0]        k;
  logic              pop;
  logic [ADDR_W-1:0] ptr;
  logic [IP_W-1:0]   asm_value;
  logic              accept;
  logic              byte_done;

  always_comb begin
    ptr = reg_hl_in;
    case (ptr_sel)
      PTR_IX:  ptr = reg_ix_in;
      PTR_IY:  ptr = reg_iy_in;
      PTR_SP:  ptr = reg_sp_in;
      default: ptr = reg_hl_in;
    endcase
  end

  assign accept    = (state == ST_IDLE) && start;
  assign byte_done = (state == ST_READ) && mem_ready;

  z80_le_assemble #(.NBYTES(NBYTES)) u_asm (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .wr    (byte_done),
    .lane  (k),
    .data  (mem_rdata),
    .value (asm_value)
  );

  // mem_raddr is kept as its own register (base + k) so it is a clean flop
  // output and wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      base       <= '0;
      k          <= 2'd0;
      pop        <= 1'b0;
      mem_rd     <= 1'b0;
      mem_raddr  <= '0;
      busy       <= 1'b0;
      reg_ip_out <= '0;
      reg_ip_wr  <= 1'b0;
      reg_sp_out <= '0;
      reg_sp_wr  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          reg_ip_wr <= 1'b0;
          reg_sp_wr <= 1'b0;
          if (start) begin
            state     <= ST_READ;
            base      <= ptr;
            mem_raddr <= ptr;
            k         <= 2'd0;
            pop       <= is_pop(ptr_sel);
            mem_rd    <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_READ: begin
          if (mem_ready) begin
            k         <= k + 2'd1;
            mem_raddr <= mem_raddr + ADDR_W'(1);
            if (k == LAST_K) begin
              state      <= ST_DONE;
              mem_rd     <= 1'b0;
              reg_ip_out <= asm_value;
              reg_ip_wr  <= 1'b1;
              reg_sp_wr  <= pop;
              if (pop) reg_sp_out <= base + ADDR_W'(NBYTES);
            end
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          reg_ip_wr <= 1'b0;
          reg_sp_wr <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          mem_rd <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z80_ind_jp_seq.sv
// Directed bench for z80_ind_jp_seq: a 2-byte instance for most scenarios
// and a 4-byte instance for the wide-target case.
module tb_z80_ind_jp_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, start4;
  logic [1:0]  sel, sel4;
  logic [15:0] hl, ix, iy, sp;
  logic        rdy, rdy4;

  logic        mem_rd, mem_rd4, busy, busy4;
  logic [15:0] raddr, raddr4;
  logic [7:0]  rdata, rdata4;
  logic [15:0] ip_out;
  logic [31:0] ip_out4;
  logic        ip_wr, ip_wr4, sp_wr, sp_wr4;
  logic [15:0] sp_out, sp_out4;

  logic [7:0] mem [0:65535];
  int pass_cnt = 0;
  int total_cnt = 0;
  int wr_cnt = 0;

  always #5 clk = ~clk;

  assign rdata  = mem[raddr];
  assign rdata4 = mem[raddr4];

  always @(posedge clk) if (ip_wr) wr_cnt++;

  z80_ind_jp_seq #(.NBYTES(2), .ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .ptr_sel(sel),
    .reg_hl_in(hl), .reg_ix_in(ix), .reg_iy_in(iy), .reg_sp_in(sp),
    .mem_rd(mem_rd), .mem_raddr(raddr), .mem_ready(rdy), .mem_rdata(rdata),
    .busy(busy), .reg_ip_out(ip_out), .reg_ip_wr(ip_wr),
    .reg_sp_out(sp_out), .reg_sp_wr(sp_wr)
  );

  z80_ind_jp_seq #(.NBYTES(4), .ADDR_W(16)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .ptr_sel(sel4),
    .reg_hl_in(hl), .reg_ix_in(ix), .reg_iy_in(iy), .reg_sp_in(sp),
    .mem_rd(mem_rd4), .mem_raddr(raddr4), .mem_ready(rdy4), .mem_rdata(rdata4),
    .busy(busy4), .reg_ip_out(ip_out4), .reg_ip_wr(ip_wr4),
    .reg_sp_out(sp_out4), .reg_sp_wr(sp_wr4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start4 = 1'b0; sel = 2'd0; sel4 = 2'd0;
    hl = 16'h0; ix = 16'h0; iy = 16'h0; sp = 16'h0; rdy = 1'b1; rdy4 = 1'b1;
    tick(); tick();
    total_cnt++;
    if ({mem_rd, busy, ip_wr, sp_wr} !== 4'b0) $display("FAIL reset_ctrl got %b want 0000", {mem_rd, busy, ip_wr, sp_wr});
    else pass_cnt++;
    total_cnt++;
    if (ip_out !== 16'h0 || sp_out !== 16'h0) $display("FAIL reset_regs ip=%h sp=%h want 0000/0000", ip_out, sp_out);
    else pass_cnt++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_hl_basic();
    int w0;
    mem[16'h1234] = 8'hCD; mem[16'h1235] = 8'hAB;
    hl = 16'h1234; sel = 2'd0; rdy = 1'b1; start = 1'b1;
    w0 = wr_cnt;
    tick(); start = 1'b0;
    total_cnt++;
    if (mem_rd !== 1'b1 || raddr !== 16'h1234 || busy !== 1'b1) $display("FAIL hl_addr0 rd=%b addr=%h busy=%b want 1/1234/1", mem_rd, raddr, busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (mem_rd !== 1'b1 || raddr !== 16'h1235) $display("FAIL hl_addr1 rd=%b addr=%h want 1/1235", mem_rd, raddr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ip_wr !== 1'b1 || ip_out !== 16'hABCD || sp_wr !== 1'b0 || mem_rd !== 1'b0)
      $display("FAIL hl_done wr=%b ip=%h spwr=%b rd=%b want 1/abcd/0/0", ip_wr, ip_out, sp_wr, mem_rd);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ip_wr !== 1'b0 || busy !== 1'b0 || ip_out !== 16'hABCD || wr_cnt - w0 !== 1)
      $display("FAIL hl_idle wr=%b busy=%b ip=%h pulses=%0d want 0/0/abcd/1", ip_wr, busy, ip_out, wr_cnt - w0);
    else pass_cnt++;
  endtask

  task automatic test_sp_pop();
    mem[16'hFFFF] = 8'h34; mem[16'h0000] = 8'h12;
    sp = 16'hFFFF; sel = 2'd3; start = 1'b1;
    tick(); start = 1'b0;
    total_cnt++;
    if (raddr !== 16'hFFFF) $display("FAIL sp_addr0 got %h want ffff", raddr);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (raddr !== 16'h0000 || mem_rd !== 1'b1) $display("FAIL sp_wrap got %h rd=%b want 0000/1", raddr, mem_rd);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ip_wr !== 1'b1 || ip_out !== 16'h1234 || sp_wr !== 1'b1 || sp_out !== 16'h0001)
      $display("FAIL sp_done wr=%b ip=%h spwr=%b sp=%h want 1/1234/1/0001", ip_wr, ip_out, sp_wr, sp_out);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (sp_wr !== 1'b0 || sp_out !== 16'h0001) $display("FAIL sp_hold spwr=%b sp=%h want 0/0001", sp_wr, sp_out);
    else pass_cnt++;
  endtask

  task automatic test_wait_states();
    int w0, bad, edges;
    mem[16'h8000] = 8'hEF; mem[16'h8001] = 8'hBE;
    ix = 16'h8000; sel = 2'd1; rdy = 1'b0; start = 1'b1;
    w0 = wr_cnt; bad = 0; edges = 0;
    tick(); start = 1'b0; edges++;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 3; i++) begin
        if (mem_rd !== 1'b1 || raddr !== 16'h8000 + 16'(b) || ip_wr !== 1'b0) bad++;
        tick(); edges++;
      end
      rdy = 1'b1;
      tick(); edges++;
      rdy = 1'b0;
    end
    total_cnt++;
    if (bad != 0) $display("FAIL wait_hold unstable samples=%0d want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (ip_wr !== 1'b1 || ip_out !== 16'hBEEF || edges != 9)
      $display("FAIL wait_done wr=%b ip=%h cycles=%0d want 1/beef/9", ip_wr, ip_out, edges);
    else pass_cnt++;
    rdy = 1'b1;
    tick(); tick();
    total_cnt++;
    if (wr_cnt - w0 !== 1) $display("FAIL wait_pulses got %0d want 1", wr_cnt - w0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int w0;
    mem[16'h2000] = 8'h55; mem[16'h2001] = 8'h66;
    mem[16'h3000] = 8'h99; mem[16'h3001] = 8'h99;
    hl = 16'h2000; sel = 2'd0; rdy = 1'b0; start = 1'b1;
    w0 = wr_cnt;
    tick();
    hl = 16'h3000; ix = 16'h3000; sel = 2'd1;
    tick(); start = 1'b0;
    total_cnt++;
    if (raddr !== 16'h2000 || busy !== 1'b1) $display("FAIL b2b_ignore addr=%h busy=%b want 2000/1", raddr, busy);
    else pass_cnt++;
    rdy = 1'b1;
    tick(); tick();
    total_cnt++;
    if (ip_wr !== 1'b1 || ip_out !== 16'h6655 || sp_wr !== 1'b0)
      $display("FAIL b2b_done wr=%b ip=%h spwr=%b want 1/6655/0", ip_wr, ip_out, sp_wr);
    else pass_cnt++;
    tick(); tick(); tick();
    total_cnt++;
    if (wr_cnt - w0 !== 1 || busy !== 1'b0) $display("FAIL b2b_pulses got %0d busy=%b want 1/0", wr_cnt - w0, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_read();
    int w0;
    mem[16'h4000] = 8'h77; mem[16'h4001] = 8'h88;
    hl = 16'h4000; sel = 2'd0; rdy = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    reset = 1'b1;
    w0 = wr_cnt;
    tick();
    total_cnt++;
    if ({mem_rd, busy, ip_wr, sp_wr} !== 4'b0 || ip_out !== 16'h0 || sp_out !== 16'h0)
      $display("FAIL rst_mid ctrl=%b ip=%h sp=%h want 0000/0000/0000", {mem_rd, busy, ip_wr, sp_wr}, ip_out, sp_out);
    else pass_cnt++;
    start = 1'b1;
    tick();
    total_cnt++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) $display("FAIL rst_prio busy=%b rd=%b want 0/0", busy, mem_rd);
    else pass_cnt++;
    start = 1'b0; reset = 1'b0;
    tick(); tick(); tick();
    total_cnt++;
    if (wr_cnt - w0 !== 0) $display("FAIL rst_nopulse got %0d want 0", wr_cnt - w0);
    else pass_cnt++;
    start = 1'b1;
    tick(); start = 1'b0;
    total_cnt++;
    if (raddr !== 16'h4000) $display("FAIL rst_restart addr=%h want 4000", raddr);
    else pass_cnt++;
    tick(); tick();
    total_cnt++;
    if (ip_wr !== 1'b1 || ip_out !== 16'h8877) $display("FAIL rst_refetch wr=%b ip=%h want 1/8877", ip_wr, ip_out);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_nbytes4();
    int edges;
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22;
    mem[16'h0102] = 8'h33; mem[16'h0103] = 8'h44;
    iy = 16'h0100; sel4 = 2'd2; rdy4 = 1'b1; start4 = 1'b1;
    tick(); start4 = 1'b0; edges = 1;
    total_cnt++;
    if (raddr4 !== 16'h0100 || mem_rd4 !== 1'b1) $display("FAIL w4_addr0 addr=%h rd=%b want 0100/1", raddr4, mem_rd4);
    else pass_cnt++;
    while (ip_wr4 !== 1'b1 && edges < 20) begin
      tick(); edges++;
    end
    total_cnt++;
    if (ip_wr4 !== 1'b1 || ip_out4 !== 32'h44332211 || edges != 5 || sp_wr4 !== 1'b0)
      $display("FAIL w4_done wr=%b ip=%h cycles=%0d spwr=%b want 1/44332211/5/0", ip_wr4, ip_out4, edges, sp_wr4);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_hl_basic();
    test_sp_pop();
    test_wait_states();
    test_back_to_back();
    test_reset_mid_read();
    test_nbytes4();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
